tmds_rx_channel: RTL

Receive-side counterpart of the per-channel TMDS encoder in the dvid path. Takes raw 10-bit words from an upstream 1:10 deserializer running at vga_clk, whose word boundary is arbitrary. Finds the symbol boundary by hunting for control-token runs during blanking, then decodes each aligned symbol back to 8-bit pixel data, or to control bits plus blank. One instance per TMDS lane; on the blue lane, c0/c1 recover hsync/vsync.

---
 rtl/tmds_rx_channel_if.sv | 23 ++
 rtl/tmds_rx_channel.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tmds_rx_channel_if.sv
// Lane-side signal bundle for tmds_rx_channel: raw deserializer word in, decoded symbol out.
// Stats ports (err_count, slip_count) exist only when TMDS_RX_STATS_EN is defined.
interface tmds_rx_channel_if;
   logic [9:0] raw_in;
   logic [7:0] data;
   logic       c0;
   logic       c1;
   logic       blank;
   logic       locked;
   logic [3:0] offset;
`ifdef TMDS_RX_STATS_EN
   logic [15:0] err_count;
   logic [7:0]  slip_count;

   modport master (output raw_in,
                   input  data, c0, c1, blank, locked, offset, err_count, slip_count);
   modport slave  (input  raw_in,
                   output data, c0, c1, blank, locked, offset, err_count, slip_count);
`else
   modport master (output raw_in, input  data, c0, c1, blank, locked, offset);
   modport slave  (input  raw_in, output data, c0, c1, blank, locked, offset);
`endif
endinterface

// File: rtl/tmds_rx_channel.sv
// Per-lane TMDS receiver: word alignment by control-token runs, then symbol decode.
// Define TMDS_RX_STATS_EN to add err_count / slip_count statistics outputs.
module tmds_rx_channel #(
   parameter int unsigned CTRL_RUN    = 8,
   parameter int unsigned TIMEOUT     = 4096,
   parameter int unsigned OFFSET_INIT = 0
) (
   input logic              clk,
   input logic              resetn,
   tmds_rx_channel_if.slave bus
);
   localparam int unsigned   TW         = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] T_MAX      = TW'(TIMEOUT - 1);
   localparam logic [7:0]    RUN_MAX    = 8'(CTRL_RUN);
   localparam logic [3:0]    OFFSET_RST = 4'(OFFSET_INIT);

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t        state, state_n;
   logic [9:0]    raw_prev, s1, aligned;
   logic [19:0]   window;
   logic [7:0]    run, run_n, run_inc;
   logic [TW-1:0] timer, timer_n;
   logic [3:0]    offset_q, offset_n;
   logic [7:0]    data_q, d, dec;
   logic          c0_q, c1_q, blank_q;
   logic          is_tok;
   logic [1:0]    tok_c;
   logic          slip, drop;

   assign window  = {bus.raw_in, raw_prev};
   assign aligned = 10'(window >> offset_q);

   always_comb begin
      is_tok = 1'b1;
      tok_c  = 2'b00;
      case (s1)
         10'b1101010100: tok_c = 2'b00;
         10'b0010101011: tok_c = 2'b01;
         10'b0101010100: tok_c = 2'b10;
         10'b1010101011: tok_c = 2'b11;
         default:        is_tok = 1'b0;
      endcase
   end

   always_comb begin
      d      = s1[9] ? ~s1[7:0] : s1[7:0];
      dec    = '0;
      dec[0] = d[0];
      for (int unsigned i = 1; i < 8; i++)
         dec[i] = s1[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
   end

   // Lock takes priority over a same-cycle search timeout, so the offset never slips away from a good run.
   always_comb begin
      state_n  = state;
      run_n    = run;
      timer_n  = timer;
      offset_n = offset_q;
      slip     = 1'b0;
      drop     = 1'b0;
      run_inc  = (run == RUN_MAX) ? run : run + 8'd1;
      case (state)
         SEARCH: begin
            if (is_tok && run_inc == RUN_MAX) begin
               state_n = LOCKED;
               run_n   = run_inc;
               timer_n = '0;
            end else if (timer == T_MAX) begin
               offset_n = (offset_q == 4'd9) ? '0 : offset_q + 4'd1;
               timer_n  = '0;
               run_n    = '0;
               slip     = 1'b1;
            end else begin
               timer_n = timer + TW'(1);
               run_n   = is_tok ? run_inc : '0;
            end
         end
         LOCKED: begin
            if (is_tok) begin
               timer_n = '0;
            end else if (timer == T_MAX) begin
               state_n = SEARCH;
               run_n   = '0;
               timer_n = '0;
               drop    = 1'b1;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         default: state_n = SEARCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         raw_prev <= '0;
         s1       <= '0;
         state    <= SEARCH;
         run      <= '0;
         timer    <= '0;
         offset_q <= OFFSET_RST;
         data_q   <= '0;
         c0_q     <= 1'b0;
         c1_q     <= 1'b0;
         blank_q  <= 1'b1;
      end else begin
         raw_prev <= bus.raw_in;
         s1       <= aligned;
         state    <= state_n;
         run      <= run_n;
         timer    <= timer_n;
         offset_q <= offset_n;
         if (is_tok) begin
            blank_q <= 1'b1;
            c0_q    <= tok_c[0];
            c1_q    <= tok_c[1];
         end else begin
            blank_q <= 1'b0;
            data_q  <= dec;
         end
      end
   end

   assign bus.data   = data_q;
   assign bus.c0     = c0_q;
   assign bus.c1     = c1_q;
   assign bus.blank  = blank_q;
   assign bus.locked = (state == LOCKED);
   assign bus.offset = offset_q;

`ifdef TMDS_RX_STATS_EN
   logic [15:0] err_q;
   logic [7:0]  slip_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         err_q  <= '0;
         slip_q <= '0;
      end else begin
         if (drop && err_q != '1)
            err_q <= err_q + 16'd1;
         if (slip)
            slip_q <= slip_q + 8'd1;
      end
   end

   assign bus.err_count  = err_q;
   assign bus.slip_count = slip_q;
`else
   logic unused_stats;
   assign unused_stats = slip ^ drop;
`endif
endmodule
